// File: rtl/glyph_fetcher.sv
// Glyph fetcher: reads a 16x16 font bitmap row by row from a synchronous ROM,
// packs it into a 256-pixel vector, then presents it for exactly 256 cycles.
module glyph_fetcher #(
  parameter int CODE_W    = 8,
  parameter int GLYPH_PIX = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  input  logic [CODE_W-1:0]   code,
  output logic                code_ready,
  output logic [CODE_W+3:0]   rom_addr,
  input  logic [15:0]         rom_data,
  output logic [0:GLYPH_PIX-1] char,
  output logic                printable,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DISPLAY} state_t;

  state_t            state, state_nxt;
  logic [CODE_W-1:0] code_q;
  logic [3:0]        issue_row, cap_row;
  logic              cap_en;
  logic [8:0]        disp_cnt;

  assign code_ready = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign printable  = (state == DISPLAY);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (code_valid)                  state_nxt = FETCH;
      FETCH:   if (cap_en && cap_row == 4'd15)  state_nxt = DISPLAY;
      DISPLAY: if (disp_cnt == 9'd255)          state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // cap_en marks that rom_data already reflects an address issued in FETCH,
  // covering the one-cycle ROM latency at the start of a fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q    <= '0;
      issue_row <= '0;
      cap_row   <= '0;
      cap_en    <= 1'b0;
      disp_cnt  <= '0;
      rom_addr  <= '0;
      char      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (code_valid) begin
            code_q    <= code;
            issue_row <= '0;
            cap_row   <= '0;
            cap_en    <= 1'b0;
            rom_addr  <= {code, 4'h0};
          end
        end
        FETCH: begin
          cap_en   <= 1'b1;
          disp_cnt <= '0;
          if (issue_row != 4'd15) begin
            issue_row <= issue_row + 4'd1;
            rom_addr  <= {code_q, issue_row + 4'd1};
          end
          // Ascending char range: char[16r] receives rom_data[15], the leftmost pixel.
          if (cap_en) begin
            char[{cap_row, 4'h0} +: 16] <= rom_data;
            if (cap_row != 4'd15) cap_row <= cap_row + 4'd1;
          end
        end
        DISPLAY: disp_cnt <= disp_cnt + 9'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_fetcher.sv
// Randomized self-checking bench for glyph_fetcher against a cycle-count
// reference model of the accept / fetch / display sequence.
module tb_glyph_fetcher;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          code_valid = 1'b0;
  logic [7:0]    code = '0;
  logic          code_ready;
  logic [11:0]   rom_addr;
  logic [15:0]   rom_data = '0;
  logic [0:255]  char;
  logic          printable;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rom_mode = 0;

  glyph_fetcher #(.CODE_W(8), .GLYPH_PIX(256)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .char(char), .printable(printable), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_row(input logic [11:0] a, input int m);
    case (m)
      0:       return 16'h8001 ^ (16'(a[3:0]) << 4);
      1:       return 16'hFFFF;
      default: return (16'(a) * 16'h9E37) ^ 16'({a[3:0], a});
    endcase
  endfunction

  // Synchronous font ROM, one-cycle read latency.
  always @(posedge clk) rom_data <= rom_row(rom_addr, rom_mode);

  function automatic logic [0:255] glyph(input logic [7:0] c, input int m);
    logic [0:255] g;
    logic [15:0]  row;
    g = '0;
    for (int r = 0; r < 16; r++) begin
      row = rom_row({c, 4'(r)}, m);
      for (int col = 0; col < 16; col++) g[16*r + col] = row[15 - col];
    end
    return g;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for code_ready at a falling edge, then offer the code.
  task automatic start(input logic [7:0] c);
    int t = 0;
    while (!code_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("start_timeout", 1, 0);
    code_valid = 1'b1;
    code = c;
  endtask

  // Follows one glyph from the accept edge; k counts cycles after that edge.
  task automatic follow(input logic [7:0] c, input bit hold, input logic [7:0] nxt,
                        input int p1, input int p2, input logic [7:0] pc,
                        input int abort_at);
    logic [0:255] e;
    logic [11:0]  ea;
    e = glyph(c, rom_mode);
    for (int k = 1; k <= 274; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        reset = 1'b1;
        code_valid = 1'b0;
        @(negedge clk);
        chk("abort_printable", printable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_char", char, 0);
        chk("abort_ready", code_ready, 0);
        chk("abort_addr", rom_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", code_ready, 1);
        return;
      end
      chk("busy", busy, k < 274);
      chk("ready", code_ready, k == 274);
      chk("printable", printable, (k >= 18) && (k <= 273));
      ea = (k <= 16) ? {c, 4'(k - 1)} : {c, 4'hF};
      chk("rom_addr", rom_addr, ea);
      if (k == 18 || k == 273) chk("char", char, e);
      if (k == 1) begin
        if (hold) code = nxt;
        else      code_valid = 1'b0;
      end else if (!hold) begin
        if (k == p1 || k == p2) begin
          code_valid = 1'b1;
          code = pc;
        end else code_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] rc, rpc;
    int rp1, rp2, rab;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", code_ready, 0);
    chk("rst_printable", printable, 0);
    chk("rst_char", char, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", code_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_printable", printable, 0);
    chk("rel_char", char, 0);

    // Single fetch of 0x41
    rom_mode = 0;
    start(8'h41);
    follow(8'h41, 0, 8'h00, 0, 0, 8'h00, 0);

    // Busy rejection: stray offers of 0x22 while 0x10 is in flight
    start(8'h10);
    follow(8'h10, 0, 8'h00, 5, 100, 8'h22, 0);

    // Back-to-back with code_valid held high
    start(8'h01);
    follow(8'h01, 1, 8'h02, 0, 0, 8'h00, 0);
    follow(8'h02, 0, 8'h00, 0, 0, 8'h00, 0);

    // Reset during FETCH and during DISPLAY, each followed by a full glyph
    rom_mode = 2;
    start(8'h33);
    follow(8'h33, 0, 8'h00, 0, 0, 8'h00, 10);
    start(8'h34);
    follow(8'h34, 0, 8'h00, 0, 0, 8'h00, 0);
    start(8'h35);
    follow(8'h35, 0, 8'h00, 0, 0, 8'h00, 167);
    start(8'h36);
    follow(8'h36, 0, 8'h00, 0, 0, 8'h00, 0);

    // Address boundary, all-ones then patterned data
    rom_mode = 1;
    start(8'hFF);
    follow(8'hFF, 0, 8'h00, 0, 0, 8'h00, 0);
    rom_mode = 2;
    start(8'hFF);
    follow(8'hFF, 0, 8'h00, 0, 0, 8'h00, 0);

    // Randomized glyphs with stray offers and occasional aborts
    for (int i = 0; i < 6; i++) begin
      rom_mode = int'($urandom_range(0, 2));
      rc  = 8'($urandom);
      rpc = 8'($urandom);
      rp1 = int'($urandom_range(2, 270));
      rp2 = int'($urandom_range(2, 270));
      rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 273)) : 0;
      start(rc);
      follow(rc, 0, 8'h00, rp1, rp2, rpc, rab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_fetcher.md
Name: glyph_fetcher

Overview:
- Producer side of the glyph display interface: accepts a character code, reads its 16x16 bitmap row by row from a synchronous font ROM, and packs it into a 256-bit glyph vector.
- Then asserts printable for exactly 256 consecutive cycles so the downstream pixel serializer steps through every pixel once and wraps back to index 0.
- Sits between the text/character source and the pixel serializer that drives VGA_R/G/B.

Parameters:
- CODE_W, 8, width of character code; ROM address width is CODE_W+4.
- GLYPH_PIX, 256, pixels per glyph (16 rows x 16 columns); fixed, not to be overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- code_valid  input  1  a character code is offered.
- code  input  CODE_W  character code to fetch.
- code_ready  output  1  block accepts a code this cycle.
- rom_addr  output  CODE_W+4  font ROM address, {code, row[3:0]}.
- rom_data  input  16  ROM row data; bit 15 = leftmost pixel.
- char  output  [0:255]  packed glyph; char[0] = top-left pixel, row-major.
- printable  output  1  glyph valid; consumer advances one pixel per high cycle.
- busy  output  1  high in FETCH or DISPLAY.

Behaviour:
- Reset, applied at any clock edge including mid-operation:
  - state=IDLE, char=0, printable=0, rom_addr=0, row counters=0, display counter=0.
  - code_ready=0 while reset is high.
  - Aborts any fetch or display; printable is low in the cycle after the reset edge.
- State IDLE: code_ready=1, busy=0, printable=0. Handshake completes on a rising edge with code_valid=1 and code_ready=1. At that edge (E0): latch code, issue row=0, cap row=0, state goes to FETCH.
- State FETCH: code_ready=0, busy=1.
  - rom_addr is registered: in cycle k it holds {latched_code, issue_row}.
  - ROM returns the data for that address in cycle k+1, one-cycle latency.
  - Cycles 1..16 after E0 present rows 0..15.
  - Cycles 2..17 capture rows 0..15: for captured row r, char[16r+c] = rom_data[15-c], c=0..15.
  - Rows not yet captured keep their old contents; they are never visible because printable=0.
  - After the row-15 capture edge (end of cycle 17), state goes to DISPLAY and disp_cnt=0.
- State DISPLAY: printable=1, busy=1, code_ready=0, char held constant.
  - disp_cnt is 9 bits and increments every cycle.
  - On the edge where disp_cnt==255, state goes to IDLE. printable is therefore high for exactly 256 cycles (cycles 18..273 after E0).
  - code_ready=1 again in cycle 274.
  - Minimum accept-to-accept spacing is 274 cycles.
- code_valid while busy is ignored; code is not latched and no state changes. The upstream must hold code_valid and code until the handshake completes.
- code changing while busy has no effect on rom_addr; the latched value is used.
- rom_addr holds its last value outside FETCH; ROM reads there are don't-care.
- Row counters are 4 bits; no wrap beyond row 15 occurs because the transition to DISPLAY is taken first.
- The serializer's pixel index must be reset together with this block. The 256-cycle printable window then leaves it at index 0 at every glyph boundary.

Test Plan:
- Reset check: assert reset 3 cycles, then release. Required: char=0, printable=0, busy=0, and code_ready=1 from the first cycle after release.
- Single fetch: offer code=0x41; ROM model returns row r data = 16'h8001 ^ (r<<4). Required:
  - rom_addr = 0x410..0x41F in cycles 1..16.
  - printable rises in cycle 18.
  - char[0]=1, char[15]=1, char[16*r+11-r]... matches the bit-reversed row mapping for every r.
  - printable stays high for exactly 256 cycles.
- Busy rejection: pulse code_valid with code=0x22 in cycle 5 and again in cycle 100 after accepting 0x10. Required: code_ready=0 both times, rom_addr upper bits stay 0x10, char reflects 0x10 only.
- Back-to-back: hold code_valid high with code=0x01, then 0x02. Required: second accept in cycle 274, and a printable gap of exactly 18 cycles (cycles 274..291 low).
- Reset mid-operation: assert reset in cycle 10 of FETCH, and separately in cycle 150 of DISPLAY. Required: printable=0 and busy=0 next cycle, char=0, and a new code is accepted right after release with the full 274-cycle sequence.
- Address boundary: code=0xFF. Required: rom_addr goes to 0xFFF on row 15 with no carry corruption; all-ones ROM data gives char all ones.
